aespim_decrypt_unit: RTL and testbench

AESPIM_DECRYPT_UNIT -- requirements
Module: aespim_decrypt_unit

---
 rtl/aespim_pkg.sv | 47 ++++
 rtl/aespim_bSbox.sv | 30 +++
 rtl/aespim_inv_mixcol.sv | 17 +
 rtl/aespim_decrypt_unit.sv | 127 ++++++++++++
 tb/tb_aespim_decrypt_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/aespim_pkg.sv
// Shared types and GF(2^8) helpers for the AES PIM decrypt datapath.
package aespim_pkg;

    // Decrypt column-step operations carried in op_code_i[2:0].
    // Codes 3'b000, 3'b110 and 3'b111 are left unassigned and act as no-ops.
    typedef enum logic [2:0] {
        DLD  = 3'b001,
        DRND = 3'b010,
        DFIN = 3'b011,
        DST  = 3'b100,
        DCLR = 3'b101
    } dec_op_e;

    localparam int NCOL = 4;

    // Reduction term of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
    localparam logic [7:0] GF_POLY = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        return gf_mul(x127, x127);
    endfunction

endpackage

// File: rtl/aespim_bSbox.sv
// Bidirectional AES S-box: forward when encrypt=1, inverse when encrypt=0.
module aespim_bSbox
    import aespim_pkg::*;
(
    input  logic       encrypt,
    input  logic [7:0] a,
    output logic [7:0] q
);

    logic [7:0] inv_aff;
    logic [7:0] inv_in;
    logic [7:0] inv_out;

    // Inverse affine transform (rotations by 1, 3, 6 plus 0x05) ahead of the field inverse.
    assign inv_aff = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

    // One shared field inverter serves both directions.
    assign inv_in  = encrypt ? a : inv_aff;
    assign inv_out = gf_inv(inv_in);

    // Forward direction finishes with the affine transform; inverse direction uses the raw inverse.
    always_comb begin
        q = inv_out;
        if (encrypt) begin
            q = inv_out ^ {inv_out[6:0], inv_out[7]} ^ {inv_out[5:0], inv_out[7:6]}
                ^ {inv_out[4:0], inv_out[7:5]} ^ {inv_out[3:0], inv_out[7:4]} ^ 8'h63;
        end
    end

endmodule

// File: rtl/aespim_inv_mixcol.sv
// Single-column InvMixColumns; row r occupies bits [8r+7:8r].
module aespim_inv_mixcol
    import aespim_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    // Each output row is the circulant {0e,0b,0d,09} product starting at its own row.
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign mixed[8*gi +: 8] = gf_mul(col[8*gi +: 8], 8'h0e)
                                ^ gf_mul(col[8*((gi + 1) % 4) +: 8], 8'h0b)
                                ^ gf_mul(col[8*((gi + 2) % 4) +: 8], 8'h0d)
                                ^ gf_mul(col[8*((gi + 3) % 4) +: 8], 8'h09);
    end

endmodule

// File: rtl/aespim_decrypt_unit.sv
// Column-serial AES decrypt round engine: one column per start_i, state commit every 4 steps.
module aespim_decrypt_unit
    import aespim_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [5:0]  op_code_i,
    input  logic [31:0] data_in_mem_i,
    input  logic [31:0] data_in_reg_i,
    output logic [31:0] data_out_o,
    output logic [1:0]  col_o,
    output logic        done_o
);

    logic [31:0] s_q [NCOL];
    logic [31:0] s_d [NCOL];
    logic [31:0] n_q [NCOL];
    logic [31:0] n_d [NCOL];
    logic [1:0]  col_q, col_d;
    logic        dirty_q, dirty_d;
    logic        done_q, done_d;

    logic [31:0] t_col;
    logic [31:0] u_col;
    logic [31:0] mix_out;
    logic [31:0] wdata;
    logic        wr;
    logic        adv;
    dec_op_e     op;
    logic        unused_op_bits;

    assign op             = dec_op_e'(op_code_i[2:0]);
    assign unused_op_bits = ^op_code_i[5:3];

    // InvShiftRows gather from the committed state, then inverse S-box per row.
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign t_col[8*gi +: 8] = s_q[col_q - 2'(gi)][8*gi +: 8];

        aespim_bSbox u_sbox (
            .encrypt (1'b0),
            .a       (t_col[8*gi +: 8]),
            .q       (u_col[8*gi +: 8])
        );
    end

    aespim_inv_mixcol u_inv_mixcol (
        .col   (u_col ^ data_in_reg_i),
        .mixed (mix_out)
    );

    // Decode the step, stage the column into N, and commit N to S at the end of a dirty group.
    always_comb begin
        s_d        = s_q;
        n_d        = n_q;
        col_d      = col_q;
        dirty_d    = dirty_q;
        done_d     = 1'b0;
        data_out_o = '0;
        wr         = 1'b0;
        adv        = 1'b0;
        wdata      = '0;
        if (start_i) begin
            case (op)
                DLD: begin
                    wr    = 1'b1;
                    adv   = 1'b1;
                    wdata = data_in_mem_i ^ data_in_reg_i;
                end
                DRND: begin
                    wr    = 1'b1;
                    adv   = 1'b1;
                    wdata = mix_out;
                end
                DFIN: begin
                    wr    = 1'b1;
                    adv   = 1'b1;
                    wdata = u_col ^ data_in_reg_i;
                end
                DST: begin
                    adv        = 1'b1;
                    data_out_o = s_q[col_q];
                end
                DCLR: begin
                    col_d   = 2'd0;
                    dirty_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (wr) begin
            n_d[col_q] = wdata;
            dirty_d    = 1'b1;
        end
        if (adv) begin
            col_d = col_q + 2'd1;
            if (col_q == 2'd3 && dirty_d) begin
                s_d     = n_d;
                dirty_d = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    // State register; asynchronous reset drops any partially built group.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NCOL; i++) begin
                s_q[i] <= '0;
                n_q[i] <= '0;
            end
            col_q   <= 2'd0;
            dirty_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            s_q     <= s_d;
            n_q     <= n_d;
            col_q   <= col_d;
            dirty_q <= dirty_d;
            done_q  <= done_d;
        end
    end

    assign col_o  = col_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_aespim_decrypt_unit.sv
// Directed bench for aespim_decrypt_unit using the FIPS-197 C.1 AES-128 inverse cipher.
module tb_aespim_decrypt_unit;
    import aespim_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [5:0]  op_code_i = '0;
    logic [31:0] data_in_mem_i = '0;
    logic [31:0] data_in_reg_i = '0;
    logic [31:0] data_out_o;
    logic [1:0]  col_o;
    logic        done_o;

    int total = 0;
    int bad   = 0;

    aespim_decrypt_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .op_code_i     (op_code_i),
        .data_in_mem_i (data_in_mem_i),
        .data_in_reg_i (data_in_reg_i),
        .data_out_o    (data_out_o),
        .col_o         (col_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        dec_op_e      op;
        logic [127:0] mem;
        logic [127:0] key;
        logic [127:0] exp;
        logic         exp_done;
    } grp_t;

    grp_t         vec [15];
    logic [127:0] rk [0:10];
    logic [127:0] ct, st1, st2, pt, mixed_exp;

    function automatic logic [31:0] get_col(input logic [127:0] v, input int c);
        logic [31:0] w;
        for (int r = 0; r < 4; r++) w[8*r +: 8] = v[127 - 8*(4*c + r) -: 8];
        return w;
    endfunction

    function automatic logic [127:0] put_col(input logic [127:0] v, input int c, input logic [31:0] w);
        logic [127:0] o;
        o = v;
        for (int r = 0; r < 4; r++) o[127 - 8*(4*c + r) -: 8] = w[8*r +: 8];
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One column step: drive at negedge, sample the combinational output, then done after the edge.
    task automatic step(input logic [5:0] opc, input logic [31:0] mem, input logic [31:0] key,
                        output logic [31:0] dout, output logic dn);
        @(negedge clk_i);
        start_i       = 1'b1;
        op_code_i     = opc;
        data_in_mem_i = mem;
        data_in_reg_i = key;
        #1 dout = data_out_o;
        @(posedge clk_i);
        #1 dn = done_o;
        $display("step op=%0d col_after=%0d out=%h done=%b", opc[2:0], col_o, dout, dn);
        start_i       = 1'b0;
        op_code_i     = '0;
        data_in_mem_i = '0;
        data_in_reg_i = '0;
    endtask

    // Four steps over columns 0..3; done must stay low until the last step.
    task automatic run_grp(input string name, input logic [5:0] opc, input logic [127:0] mem,
                           input logic [127:0] key, input logic [127:0] exp, input logic exp_done);
        logic [127:0] got;
        logic [31:0]  w;
        logic         d;
        got = '0;
        for (int c = 0; c < 4; c++) begin
            chk({name, " col"}, col_o, c);
            step(opc, get_col(mem, c), get_col(key, c), w, d);
            got = put_col(got, c, w);
            chk({name, " done"}, d, (c == 3) ? exp_done : 1'b0);
        end
        if (opc[2:0] == DST) chk({name, " state"}, got, exp);
    endtask

    initial begin
        logic [31:0] w;
        logic        d;

        ct    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        st1   = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
        st2   = 128'h54d990a16ba09ab596bbf40ea111702f;
        pt    = 128'h00112233445566778899aabbccddeeff;
        rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        vec[0]  = '{DLD,  ct, rk[10], '0,  1'b1};
        vec[1]  = '{DST,  '0, '0,     st1, 1'b0};
        vec[2]  = '{DRND, '0, rk[9],  '0,  1'b1};
        vec[3]  = '{DST,  '0, '0,     st2, 1'b0};
        for (int k = 0; k < 8; k++) vec[4 + k] = '{DRND, '0, rk[8 - k], '0, 1'b1};
        vec[12] = '{DFIN, '0, rk[0],  '0,  1'b1};
        vec[13] = '{DST,  '0, '0,     pt,  1'b0};
        vec[14] = '{DST,  '0, '0,     pt,  1'b0};

        // Reset state while rst_ni is held low.
        #12;
        chk("rst data_out", data_out_o, 32'h0);
        chk("rst col", col_o, 2'd0);
        chk("rst done", done_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("idle data_out", data_out_o, 32'h0);

        // Full inverse cipher plus DST read-backs and a DST-only group.
        for (int i = 0; i < 15; i++) begin
            run_grp($sformatf("vec%0d", i), {3'b000, vec[i].op}, vec[i].mem, vec[i].key,
                    vec[i].exp, vec[i].exp_done);
        end
        chk("wrap col", col_o, 2'd0);

        // Undefined op codes: no advance, no output, no done.
        step(6'b000000, 32'hffffffff, 32'h0, w, d);
        chk("undef0 col", col_o, 2'd0);
        chk("undef0 out", w, 32'h0);
        step(6'b111110, 32'hffffffff, 32'h0, w, d);
        chk("undef6 col", col_o, 2'd0);
        step(6'b000111, 32'hffffffff, 32'h0, w, d);
        chk("undef7 col", col_o, 2'd0);
        chk("undef7 done", d, 1'b0);

        // DCLR mid-group restarts at column 0 and suppresses the commit.
        step({3'b000, DLD}, get_col(ct, 0), get_col(rk[10], 0), w, d);
        step({3'b000, DLD}, get_col(ct, 1), get_col(rk[10], 1), w, d);
        chk("pre-clr col", col_o, 2'd2);
        step({3'b000, DCLR}, 32'h0, 32'h0, w, d);
        chk("clr col", col_o, 2'd0);
        chk("clr done", d, 1'b0);
        run_grp("reload", {3'b000, DLD}, ct, rk[10], '0, 1'b1);
        run_grp("reload rd", {3'b101, DST}, '0, '0, st1, 1'b0);

        // Mixed group: DST reads pre-commit state, DLD on column 3 alone triggers the commit.
        for (int c = 0; c < 3; c++) begin
            step({3'b000, DST}, 32'h0, 32'h0, w, d);
            chk($sformatf("mixed dst%0d", c), w, get_col(st1, c));
        end
        step({3'b000, DLD}, 32'h12345678, 32'h0, w, d);
        chk("mixed done", d, 1'b1);
        mixed_exp = 128'h7ad5fda789ef4e272bca100b78563412;
        run_grp("mixed rd", {3'b000, DST}, '0, '0, mixed_exp, 1'b0);

        // Asynchronous reset after two DRND steps discards the partial group.
        step({3'b000, DRND}, 32'h0, get_col(rk[9], 0), w, d);
        step({3'b000, DRND}, 32'h0, get_col(rk[9], 1), w, d);
        @(negedge clk_i);
        rst_ni    = 1'b0;
        start_i   = 1'b1;
        op_code_i = {3'b000, DST};
        #1;
        chk("mid rst data_out", data_out_o, 32'h0);
        chk("mid rst col", col_o, 2'd0);
        chk("mid rst done", done_o, 1'b0);
        start_i   = 1'b0;
        op_code_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        step({3'b000, DST}, 32'h0, 32'h0, w, d);
        chk("post rst dst", w, 32'h0);
        chk("post rst col", col_o, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
